// File: rtl/video_frame_writer.sv
// video_frame_writer: double-buffered 8-byte video frame store.
// Byte writes and a sequenced clear hit the back buffer; commits copy it to the front on refresh ticks.
`default_nettype none

module video_frame_writer #(
  parameter int         REFRESH_DIV = 50000,
  parameter logic [7:0] BLANK_VALUE = 8'h00
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Wr_En,
  input  logic [2:0] Wr_Addr,
  input  logic [7:0] Wr_Data,
  input  logic       Clear_Req,
  input  logic       Commit_Req,
  output logic       Busy,
  output logic       Commit_Pending,
  output logic       Frame_Tick,
  output logic [7:0] Video_Input0,
  output logic [7:0] Video_Input1,
  output logic [7:0] Video_Input2,
  output logic [7:0] Video_Input3,
  output logic [7:0] Video_Input4,
  output logic [7:0] Video_Input5,
  output logic [7:0] Video_Input6,
  output logic [7:0] Video_Input7
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state, state_next;
  logic [2:0]       idx, idx_next;
  logic [CNT_W-1:0] tick_cnt;
  logic [7:0]       back  [8];
  logic [7:0]       front [8];
  logic             commit_fire;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tick_cnt   <= '0;
      Frame_Tick <= 1'b0;
    end else if (tick_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      tick_cnt   <= '0;
      Frame_Tick <= 1'b1;
    end else begin
      tick_cnt   <= tick_cnt + 1'b1;
      Frame_Tick <= 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (Clear_Req) begin
          state_next = CLEAR;
          idx_next   = 3'd0;
        end
      end
      CLEAR: begin
        idx_next = idx + 3'd1;
        if (idx == 3'd7) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A write accepted alongside Clear_Req lands now and is blanked by the sweep later.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) back[i] <= 8'h00;
    end else if (state == CLEAR) begin
      back[idx] <= BLANK_VALUE;
    end else if (Wr_En) begin
      back[Wr_Addr] <= Wr_Data;
    end
  end

  assign commit_fire = Frame_Tick && (state == IDLE) && (Commit_Pending || Commit_Req);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) front[i] <= 8'h00;
      Commit_Pending <= 1'b0;
    end else if (commit_fire) begin
      for (int i = 0; i < 8; i++) front[i] <= back[i];
      Commit_Pending <= 1'b0;
    end else if (Commit_Req) begin
      Commit_Pending <= 1'b1;
    end
  end

  assign Busy         = (state == CLEAR);
  assign Video_Input0 = front[0];
  assign Video_Input1 = front[1];
  assign Video_Input2 = front[2];
  assign Video_Input3 = front[3];
  assign Video_Input4 = front[4];
  assign Video_Input5 = front[5];
  assign Video_Input6 = front[6];
  assign Video_Input7 = front[7];

endmodule

`default_nettype wire

// File: tb/tb_video_frame_writer.sv
// tb_video_frame_writer: directed and random stimulus against a behavioural frame-buffer model.
`default_nettype none

module tb_video_frame_writer;

  localparam int         DIV   = 4;
  localparam logic [7:0] BLANK = 8'hE7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       clear_req = 1'b0;
  logic       commit_req = 1'b0;
  logic       busy, pending, tick;
  logic [7:0] vi [8];

  int total = 0;
  int bad   = 0;

  video_frame_writer #(.REFRESH_DIV(DIV), .BLANK_VALUE(BLANK)) dut (
    .Clock(clk), .Reset(rst), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Clear_Req(clear_req), .Commit_Req(commit_req), .Busy(busy),
    .Commit_Pending(pending), .Frame_Tick(tick),
    .Video_Input0(vi[0]), .Video_Input1(vi[1]), .Video_Input2(vi[2]), .Video_Input3(vi[3]),
    .Video_Input4(vi[4]), .Video_Input5(vi[5]), .Video_Input6(vi[6]), .Video_Input7(vi[7])
  );

  always #5 clk = ~clk;

  // Reference model: frame buffers as arrays, clear as a countdown of remaining bytes.
  logic [7:0] back_m  [8];
  logic [7:0] front_m [8];
  bit         pend_m, tick_m;
  int         clear_left, edge_cnt;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 8; i++) begin back_m[i] = 8'h00; front_m[i] = 8'h00; end
        pend_m = 0; tick_m = 0; clear_left = 0; edge_cnt = 0;
      end else begin
        if (tick_m && clear_left == 0 && (pend_m || commit_req)) begin
          for (int i = 0; i < 8; i++) front_m[i] = back_m[i];
          pend_m = 0;
        end else if (commit_req) begin
          pend_m = 1;
        end
        if (clear_left > 0) begin
          back_m[8 - clear_left] = BLANK;
          clear_left--;
        end else begin
          if (wr_en) back_m[wr_addr] = wr_data;
          if (clear_req) clear_left = 8;
        end
        edge_cnt++;
        tick_m = (edge_cnt % DIV) == 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) chk($sformatf("video%0d", i), int'(vi[i]), int'(front_m[i]));
      chk("busy", int'(busy), (clear_left > 0) ? 1 : 0);
      chk("pending", int'(pending), int'(pend_m));
      chk("tick", int'(tick), int'(tick_m));
    end
  end

  task automatic cyc(input bit we, input bit [2:0] wa, input bit [7:0] wd, input bit cr, input bit cm);
    wr_en = we; wr_addr = wa; wr_data = wd; clear_req = cr; commit_req = cm;
    @(negedge clk);
    wr_en = 1'b0; clear_req = 1'b0; commit_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 3'd0, 8'h00, 0, 0);
  endtask

  task automatic wait_commit();
    int k = 0;
    while (pending && k < 20) begin idle(1); k++; end
    chk("commit_timeout", int'(pending), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) chk("reset_video", int'(vi[i]), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pending), 0);
    rst = 1'b0;

    for (int c = 1; c <= 12; c++) begin
      idle(1);
      chk("tick_phase", int'(tick), (c % 4 == 0) ? 1 : 0);
    end

    cyc(1, 3'd2, 8'h5A, 0, 0);
    idle(12);
    chk("no_commit_v2", int'(vi[2]), 0);
    cyc(0, 3'd0, 8'h00, 0, 1);
    chk("pending_set", int'(pending), 1);
    wait_commit();
    chk("commit_v2", int'(vi[2]), 8'h5A);

    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 8'(8'h10 + i), 0, 0);
    cyc(0, 3'd0, 8'h00, 0, 1);
    wait_commit();
    cyc(0, 3'd0, 8'h00, 1, 0);
    n = 0;
    while (busy && n < 20) begin n++; cyc(1, 3'(n), 8'hCC, 0, 0); end
    chk("busy_len", n, 8);
    chk("front_kept0", int'(vi[0]), 8'h10);
    chk("front_kept7", int'(vi[7]), 8'h17);
    cyc(0, 3'd0, 8'h00, 0, 1);
    wait_commit();
    for (int i = 0; i < 8; i++) chk("cleared_video", int'(vi[i]), int'(BLANK));

    for (int i = 0; i < 8; i++) cyc(1, 3'(i), 8'(8'h20 + i), 0, 0);
    cyc(0, 3'd0, 8'h00, 0, 1);
    wait_commit();
    chk("refill_v3", int'(vi[3]), 8'h23);
    cyc(0, 3'd0, 8'h00, 1, 0);
    cyc(0, 3'd0, 8'h00, 0, 1);
    idle(5);
    chk("held_during_clear", int'(vi[3]), 8'h23);
    chk("held_pending", int'(pending), 1);
    n = 0;
    while (busy && n < 20) begin n++; idle(1); end
    wait_commit();
    for (int i = 0; i < 8; i++) chk("clear_commit_video", int'(vi[i]), int'(BLANK));

    n = 0;
    while (!tick && n < 10) begin n++; idle(1); end
    cyc(1, 3'd5, 8'hFF, 0, 1);
    chk("same_cycle_v5", int'(vi[5]), int'(BLANK));
    chk("consumed_pending", int'(pending), 0);
    cyc(0, 3'd0, 8'h00, 0, 1);
    wait_commit();
    chk("second_commit_v5", int'(vi[5]), 8'hFF);

    cyc(0, 3'd0, 8'h00, 1, 0);
    cyc(0, 3'd0, 8'h00, 0, 1);
    idle(2);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) chk("async_reset_video", int'(vi[i]), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_pending", int'(pending), 0);
    chk("async_reset_tick", int'(tick), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      idle(1);
      chk("tick_restart", int'(tick), (c % 4 == 0) ? 1 : 0);
      chk("idle_after_reset", int'(busy), 0);
    end

    for (int r = 0; r < 600; r++) begin
      cyc(($urandom_range(0, 99) < 60), 3'($urandom_range(0, 7)), 8'($urandom),
          ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 20));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
